// File: rtl/hsdaoh_pkg.sv
`default_nettype none
// ============================================================================
// hsdaoh_pkg : shared word width, packer slot encoding and parameter checks
// Rev 1.0
// ============================================================================
package hsdaoh_pkg;

    localparam int HSDAOH_WORD_W = 16;

    typedef enum logic {
        SLOT_LOW  = 1'b0,
        SLOT_HIGH = 1'b1
    } slot_e;

    // A full window of 2*DECIM ones must still fit in one SUM_W-bit field.
    function automatic bit decim_legal(input int decim, input int sum_w);
        return (decim >= 2) && (decim <= 127) && ((2 * decim) < (1 << sum_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_1bit_integrator.sv
`default_nettype none
// ============================================================================
// sdr_1bit_integrator : sums both IDDR phases over DECIM cycles
// Rev 1.0
// ============================================================================
module sdr_1bit_integrator #(
    parameter int DECIM = 4,
    parameter int SUM_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_q0,
    input  logic             i_q1,
    output logic             o_sum_valid,
    output logic [SUM_W-1:0] o_sum
);

    localparam int              PH_W      = $clog2(DECIM);
    localparam logic [PH_W-1:0] C_PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]  r_phase;
    logic [SUM_W-1:0] r_acc;
    logic [1:0]       w_inc;
    logic             w_last;

    assign w_inc  = {1'b0, i_q0} + {1'b0, i_q1};
    assign w_last = i_en && (r_phase == C_PH_LAST);

    // The completed sum includes the boundary cycle's pair, so no sample is lost.
    assign o_sum       = r_acc + SUM_W'(w_inc);
    assign o_sum_valid = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else if (w_last) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else begin
            r_phase <= r_phase + PH_W'(1);
            r_acc   <= o_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdr_1bit_packer.sv
`default_nettype none
// ============================================================================
// sdr_1bit_packer : packs two integrated sums per 16-bit FIFO word, counts drops
// Rev 1.0
// ============================================================================
module sdr_1bit_packer
    import hsdaoh_pkg::*;
#(
    parameter int DECIM  = 4,
    parameter int SUM_W  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk_data,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     rf_q0,
    input  logic                     rf_q1,
    input  logic                     fifo_full,
    input  logic                     clr_overflow,
    output logic [HSDAOH_WORD_W-1:0] fifo_wdata,
    output logic                     fifo_winc,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    generate
        if (!decim_legal(DECIM, SUM_W) || (2 * SUM_W != HSDAOH_WORD_W)) begin : g_bad_params
            $error("sdr_1bit_packer: illegal DECIM/SUM_W combination");
        end
    endgenerate

    localparam logic [DROP_W-1:0] C_DROP_MAX = '1;

    logic                     w_sum_valid;
    logic [SUM_W-1:0]         w_sum;
    slot_e                    r_slot;
    slot_e                    w_slot_nxt;
    logic                     w_low_load;
    logic                     w_word_done;
    logic                     w_drop;
    logic [HSDAOH_WORD_W-1:0] w_word;
    logic [SUM_W-1:0]         r_low;
    logic [HSDAOH_WORD_W-1:0] r_wdata;
    logic                     r_winc;
    logic                     r_overflow;
    logic [DROP_W-1:0]        r_drop;

    sdr_1bit_integrator #(
        .DECIM (DECIM),
        .SUM_W (SUM_W)
    ) u_integrator (
        .i_clk       (clk_data),
        .i_rst_n     (rstn),
        .i_en        (en),
        .i_q0        (rf_q0),
        .i_q1        (rf_q1),
        .o_sum_valid (w_sum_valid),
        .o_sum       (w_sum)
    );

    always_ff @(posedge clk_data or negedge rstn) begin
        if (!rstn) begin
            r_slot <= SLOT_LOW;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    always_comb begin
        w_slot_nxt  = r_slot;
        w_low_load  = 1'b0;
        w_word_done = 1'b0;
        if (!en) begin
            w_slot_nxt = SLOT_LOW;
        end else if (w_sum_valid) begin
            case (r_slot)
                SLOT_LOW: begin
                    w_low_load = 1'b1;
                    w_slot_nxt = SLOT_HIGH;
                end
                SLOT_HIGH: begin
                    w_word_done = 1'b1;
                    w_slot_nxt  = SLOT_LOW;
                end
                default: w_slot_nxt = SLOT_LOW;
            endcase
        end
    end

    assign w_word = {w_sum, r_low};
    assign w_drop = w_word_done && fifo_full;

    always_ff @(posedge clk_data or negedge rstn) begin
        if (!rstn) begin
            r_low   <= '0;
            r_wdata <= '0;
            r_winc  <= 1'b0;
        end else begin
            if (w_low_load) begin
                r_low <= w_sum;
            end
            r_winc <= w_word_done && !fifo_full;
            if (w_word_done && !fifo_full) begin
                r_wdata <= w_word;
            end
        end
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_ff @(posedge clk_data or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow) begin
                r_drop <= DROP_W'(1);
            end else if (r_drop != C_DROP_MAX) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end
    end

    assign fifo_wdata = r_wdata;
    assign fifo_winc  = r_winc;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sdr_1bit_packer.sv
`default_nettype none
// ============================================================================
// tb_sdr_1bit_packer : directed plus randomized checks against a window model
// Rev 1.0
// ============================================================================
module tb_sdr_1bit_packer;

    localparam int DECIM = 4;
    localparam int SAT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn = 1'b0;
    logic        en = 1'b0, q0 = 1'b0, q1 = 1'b0, full = 1'b0, clr = 1'b0;
    logic [15:0] wdata, wdata_s;
    logic        winc, winc_s, ovf, ovf_s;
    logic [15:0] dcnt;
    logic [SAT_W-1:0] dcnt_s;

    sdr_1bit_packer #(.DECIM(DECIM), .SUM_W(8), .DROP_W(16)) dut (
        .clk_data(clk), .rstn(rstn), .en(en), .rf_q0(q0), .rf_q1(q1),
        .fifo_full(full), .clr_overflow(clr),
        .fifo_wdata(wdata), .fifo_winc(winc), .overflow(ovf), .drop_count(dcnt)
    );

    // Narrow drop counter so saturation is reachable in a short run.
    sdr_1bit_packer #(.DECIM(DECIM), .SUM_W(8), .DROP_W(SAT_W)) dut_sat (
        .clk_data(clk), .rstn(rstn), .en(en), .rf_q0(q0), .rf_q1(q1),
        .fifo_full(full), .clr_overflow(clr),
        .fifo_wdata(wdata_s), .fifo_winc(winc_s), .overflow(ovf_s), .drop_count(dcnt_s)
    );

    int n_vec = 0;
    int n_err = 0;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: collect enabled sample pairs; every 2*DECIM of them form one word.
    int unsigned samples[$];
    logic [15:0] m_wdata = '0;
    bit          m_winc  = 1'b0;
    bit          m_ovf   = 1'b0;
    int unsigned m_drops = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            samples.delete();
            m_wdata = '0;
            m_winc  = 1'b0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            bit drop_evt;
            drop_evt = 1'b0;
            m_winc   = 1'b0;
            if (!en) begin
                samples.delete();
            end else begin
                samples.push_back(int'(q0) + int'(q1));
                if (samples.size() == 2 * DECIM) begin
                    int lo, hi;
                    lo = 0;
                    hi = 0;
                    for (int i = 0; i < DECIM; i++) begin
                        lo += samples[i];
                        hi += samples[i + DECIM];
                    end
                    samples.delete();
                    if (full) begin
                        drop_evt = 1'b1;
                        m_ovf    = 1'b1;
                        m_drops  = clr ? 1 : m_drops + 1;
                    end else begin
                        m_winc  = 1'b1;
                        m_wdata = {hi[7:0], lo[7:0]};
                    end
                end
            end
            if (clr && !drop_evt) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    end

    function automatic int unsigned sat(input int unsigned v, input int w);
        int unsigned mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("wdata",   32'(wdata),   32'(m_wdata));
            chk("winc",    32'(winc),    32'(m_winc));
            chk("ovf",     32'(ovf),     32'(m_ovf));
            chk("dcnt",    32'(dcnt),    sat(m_drops, 16));
            chk("wdata_s", 32'(wdata_s), 32'(m_wdata));
            chk("winc_s",  32'(winc_s),  32'(m_winc));
            chk("ovf_s",   32'(ovf_s),   32'(m_ovf));
            chk("dcnt_s",  32'(dcnt_s),  sat(m_drops, SAT_W));
        end
    end

    task automatic step(input bit e, input bit a, input bit b, input bit f, input bit c);
        en = e; q0 = a; q1 = b; full = f; clr = c;
        @(negedge clk);
    endtask

    int wcount;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wdata", 32'(wdata), 32'h0);
        chk("rst_winc",  32'(winc),  32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);
        chk("rst_dcnt",  32'(dcnt),  32'h0);
        rstn   = 1'b1;
        chk_on = 1'b1;

        // All ones: strobe on cycle 8 and 16 only, word 0x0808.
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 1, 0, 0);
            if (k == 7)  chk("s1_no_early", 32'(winc), 32'h0);
            if (k == 8)  begin chk("s1_winc8", 32'(winc), 32'h1); chk("s1_w0808", 32'(wdata), 32'h0808); end
            if (k == 9)  chk("s1_not_b2b", 32'(winc), 32'h0);
            if (k == 16) chk("s1_winc16", 32'(winc), 32'h1);
        end
        step(0, 0, 0, 0, 0);

        // q0 only, then byte-order check with ones then zeros.
        for (int k = 1; k <= 8; k++) step(1, 1, 0, 0, 0);
        chk("s2_w0404", 32'(wdata), 32'h0404);
        for (int k = 1; k <= 8; k++) step(1, k <= 4, k <= 4, 0, 0);
        chk("s2_w0008", 32'(wdata), 32'h0008);

        // Drop a word, then the next word is written normally.
        for (int k = 1; k <= 8; k++) step(1, 1, 1, k == 8, 0);
        chk("s3_drop_winc", 32'(winc), 32'h0);
        chk("s3_ovf",       32'(ovf),  32'h1);
        chk("s3_dcnt",      32'(dcnt), 32'h1);
        for (int k = 1; k <= 8; k++) step(1, 0, 1, 0, 0);
        chk("s3_after_w", 32'(wdata), 32'h0404);
        chk("s3_after_s", 32'(winc),  32'h1);

        // Clear coinciding with a drop, then clear alone.
        for (int k = 1; k <= 8; k++) step(1, 1, 1, k == 8, k == 8);
        chk("s4_clrdrop_ovf",  32'(ovf),  32'h1);
        chk("s4_clrdrop_dcnt", 32'(dcnt), 32'h1);
        step(0, 0, 0, 0, 1);
        chk("s4_clr_ovf",  32'(ovf),  32'h0);
        chk("s4_clr_dcnt", 32'(dcnt), 32'h0);

        // Eight consecutive drops saturate the narrow counter.
        for (int k = 1; k <= 8 * 2 * DECIM; k++) step(1, 1, 0, 1, 0);
        chk("s5_dcnt8",   32'(dcnt),   32'h8);
        chk("s5_sat_max", 32'(dcnt_s), 32'h7);
        step(0, 0, 0, 0, 0);

        // Partial word discarded by en=0, first strobe 8 cycles after re-enable.
        wcount = 0;
        for (int k = 1; k <= 6; k++) begin step(1, 1, 1, 0, 0); wcount += int'(winc); end
        for (int k = 1; k <= 3; k++) begin step(0, 1, 1, 0, 0); wcount += int'(winc); end
        for (int k = 1; k <= 7; k++) begin step(1, 1, 1, 0, 0); wcount += int'(winc); end
        chk("s6_no_partial", 32'(wcount), 32'h0);
        step(1, 1, 1, 0, 0);
        chk("s6_winc8", 32'(winc),  32'h1);
        chk("s6_w0808", 32'(wdata), 32'h0808);

        // Asynchronous reset between edges mid-window.
        for (int k = 1; k <= 5; k++) step(1, 1, 1, 0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("s7_rst_wdata", 32'(wdata), 32'h0);
        chk("s7_rst_winc",  32'(winc),  32'h0);
        chk("s7_rst_ovf",   32'(ovf),   32'h0);
        chk("s7_rst_dcnt",  32'(dcnt),  32'h0);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1, 1, 1, 0, 0);
            if (k == 7) chk("s7_no_early", 32'(winc), 32'h0);
            if (k == 8) begin chk("s7_winc8", 32'(winc), 32'h1); chk("s7_w0808", 32'(wdata), 32'h0808); end
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 29) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end
        step(0, 0, 0, 0, 0);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
